// File: rtl/co_mux_pkg.sv
// rtl/co_mux_pkg.sv - shared FSM encoding and width helper for arb_mux_n
package co_mux_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// rtl/arb_mux_n_if.sv - channel/output handshake bundle for arb_mux_n
interface arb_mux_n_if #(
  parameter int size = 32,
  parameter int ch   = 4
);
  localparam int sel_w = co_mux_pkg::clog2(ch);

  logic [ch-1:0]      valid_i;
  logic [ch-1:0]      last_i;
  logic [ch*size-1:0] data_i;
  logic [ch-1:0]      ready_o;
  logic               force_en_i;
  logic [sel_w-1:0]   force_sel_i;
  logic               valid_o;
  logic               last_o;
  logic [size-1:0]    data_o;
  logic [sel_w-1:0]   grant_o;
  logic               ready_i;

  modport master (
    output valid_i, last_i, data_i, force_en_i, force_sel_i, ready_i,
    input  ready_o, valid_o, last_o, data_o, grant_o
  );

  modport slave (
    input  valid_i, last_i, data_i, force_en_i, force_sel_i, ready_i,
    output ready_o, valid_o, last_o, data_o, grant_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational search from ptr+1 (mod ch) for first request
module rr_arbiter #(
  parameter int ch    = 4,
  parameter int sel_w = 2
) (
  input  logic [ch-1:0]    req,
  input  logic [sel_w-1:0] ptr,
  output logic [ch-1:0]    gnt,
  output logic [sel_w-1:0] idx,
  output logic             any
);

  logic [sel_w-1:0] cand;

  // Walk the channels starting just after ptr; a pointer of ch-1 gives
  // plain lowest-index-first priority.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= ch; i++) begin
      cand = sel_w'((int'(ptr) + i) % ch);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// rtl/arb_mux_n.sv - registered N-to-1 packet mux; ARB_MUX_RR_EN selects round-robin
module arb_mux_n
  import co_mux_pkg::*;
#(
  parameter int size = 32,
  parameter int ch   = 4
) (
  input logic       clk_i,
  input logic       rst_i,
  arb_mux_n_if.slave bus
);

  localparam int sel_w = clog2(ch);

  state_t           state;
  logic [sel_w-1:0] lock_ch;
  logic [sel_w-1:0] ptr;
  logic [ch-1:0]    req;
  logic [ch-1:0]    win_gnt;
  logic [sel_w-1:0] win_idx;
  logic             win_any;
  logic [size-1:0]  win_data;
  logic             win_last;
  logic             take;
  logic             accept;

  assign take   = !bus.valid_o || bus.ready_i;
  assign accept = rst_i && take && win_any;

  // Eligible channels: the locked one mid-packet, else valid_i narrowed by force.
  always_comb begin
    req = '0;
    if (state == ST_LOCK) begin
      req[lock_ch] = bus.valid_i[lock_ch];
    end else if (!bus.force_en_i) begin
      req = bus.valid_i;
    end else if (int'(bus.force_sel_i) < ch) begin
      req[bus.force_sel_i] = bus.valid_i[bus.force_sel_i];
    end
  end

  rr_arbiter #(.ch(ch), .sel_w(sel_w)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Select the winning channel's beat using the one-hot grant.
  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int k = 0; k < ch; k++) begin
      if (win_gnt[k]) begin
        win_data = bus.data_i[k*size +: size];
        win_last = bus.last_i[k];
      end
    end
  end

  assign bus.ready_o = accept ? win_gnt : '0;

`ifdef ARB_MUX_RR_EN
  // Pointer remembers the last ARB winner so the next search starts after it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr <= sel_w'(ch - 1);
    end else if (accept && state == ST_ARB) begin
      ptr <= win_idx;
    end
  end
`else
  assign ptr = sel_w'(ch - 1);
`endif

  // Packet-lock FSM and output register, loaded whenever the slot is free.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= ST_ARB;
      lock_ch     <= '0;
      bus.valid_o <= 1'b0;
      bus.last_o  <= 1'b0;
      bus.data_o  <= '0;
      bus.grant_o <= '0;
    end else if (take) begin
      if (win_any) begin
        bus.valid_o <= 1'b1;
        bus.data_o  <= win_data;
        bus.last_o  <= win_last;
        bus.grant_o <= win_idx;
        if (state == ST_ARB) begin
          if (!win_last) begin
            state   <= ST_LOCK;
            lock_ch <= win_idx;
          end
        end else if (win_last) begin
          state <= ST_ARB;
        end
      end else begin
        bus.valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// tb/tb_arb_mux_n.sv - directed bench with cycle-level reference model for arb_mux_n
module tb_arb_mux_n;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  arb_mux_n_if #(.size(32), .ch(4)) bus ();
  arb_mux_n_if #(.size(32), .ch(3)) bus3 ();

  arb_mux_n #(.size(32), .ch(4)) dut  (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  arb_mux_n #(.size(32), .ch(3)) dut3 (.clk_i(clk), .rst_i(rst_n), .bus(bus3));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected registered outputs plus packet/pointer bookkeeping.
  logic        m_valid = 1'b0;
  logic        m_last  = 1'b0;
  logic [31:0] m_data  = '0;
  int          m_grant = 0;
  int          m_lock  = -1;
  int          m_ptr   = 3;

  always @(negedge clk) begin
    int   w;
    int   start;
    logic tk;
    logic [3:0] er;
    chk("m_valid_o", bus.valid_o, m_valid);
    chk("m_last_o", bus.last_o, m_last);
    chk("m_data_o", bus.data_o, m_data);
    chk("m_grant_o", bus.grant_o, m_grant);
    tk = !m_valid || bus.ready_i;
`ifdef ARB_MUX_RR_EN
    start = (m_ptr + 1) % 4;
`else
    start = 0;
`endif
    w = -1;
    if (m_lock >= 0) begin
      if (bus.valid_i[m_lock]) w = m_lock;
    end else if (bus.force_en_i) begin
      if (bus.valid_i[bus.force_sel_i]) w = int'(bus.force_sel_i);
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w < 0 && bus.valid_i[(start + n) % 4]) w = (start + n) % 4;
      end
    end
    er = (rst_n && tk && w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("m_ready_o", bus.ready_o, er);
    if (!rst_n) begin
      m_valid = 1'b0; m_last = 1'b0; m_data = '0; m_grant = 0; m_lock = -1; m_ptr = 3;
    end else if (tk) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = bus.data_i[w*32 +: 32];
        m_last  = bus.last_i[w];
        m_grant = w;
        if (m_lock < 0) begin
          m_ptr = w;
          if (!bus.last_i[w]) m_lock = w;
        end else if (bus.last_i[w]) begin
          m_lock = -1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  int seq[5];
  int lk[4];
`ifdef ARB_MUX_RR_EN
  int exp_seq[5] = '{0, 1, 2, 3, 0};
  int exp_lk[4]  = '{2, 2, 2, 3};
  logic [3:0] exp_after_lock = 4'b1000;
`else
  int exp_seq[5] = '{0, 0, 0, 0, 0};
  int exp_lk[4]  = '{2, 2, 2, 0};
  logic [3:0] exp_after_lock = 4'b0001;
`endif

  initial begin
    rst_n           = 1'b0;
    bus.valid_i     = 4'hF;
    bus.last_i      = 4'hF;
    bus.data_i      = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bus.force_en_i  = 1'b0;
    bus.force_sel_i = 2'd0;
    bus.ready_i     = 1'b1;
    bus3.valid_i     = 3'b111;
    bus3.last_i      = 3'b111;
    bus3.data_i      = {32'h33330002, 32'h33330001, 32'h33330000};
    bus3.force_en_i  = 1'b1;
    bus3.force_sel_i = 2'd3;
    bus3.ready_i     = 1'b1;

    // Reset held two cycles with every channel valid.
    step(); step();
    chk("rst_valid_o", bus.valid_o, 1'b0);
    chk("rst_data_o", bus.data_o, 32'h0);
    chk("rst_ready_o", bus.ready_o, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_o", bus.ready_o, 4'b0001);

    // Single-beat packets from all channels: fairness order.
    step();
    seq[0] = int'(bus.grant_o);
    for (int i = 1; i < 5; i++) begin
      step();
      seq[i] = int'(bus.grant_o);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("seq_grant%0d", i), seq[i], exp_seq[i]);

    // Three-beat packet on ch2 with others valid; force changes ignored in lock.
    bus.force_en_i  = 1'b1;
    bus.force_sel_i = 2'd2;
    bus.last_i      = 4'b1011;
    step();
    lk[0] = int'(bus.grant_o);
    bus.force_sel_i = 2'd0;
    #1;
    chk("lock_ready_b2", bus.ready_o, 4'b0100);
    step();
    lk[1] = int'(bus.grant_o);
    bus.last_i = 4'hF;
    #1;
    chk("lock_ready_b3", bus.ready_o, 4'b0100);
    step();
    lk[2] = int'(bus.grant_o);
    bus.force_en_i = 1'b0;
    #1;
    chk("unlock_ready", bus.ready_o, exp_after_lock);
    step();
    lk[3] = int'(bus.grant_o);
    for (int i = 0; i < 4; i++) chk($sformatf("lock_grant%0d", i), lk[i], exp_lk[i]);

    // Backpressure: held beat stays put while ready_i is low.
    bus.valid_i        = 4'b0001;
    bus.data_i[31:0]   = 32'hA5A5A5A5;
    step();
    chk("bp_load", bus.data_o, 32'hA5A5A5A5);
    bus.ready_i      = 1'b0;
    bus.data_i[31:0] = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_data_hold", bus.data_o, 32'hA5A5A5A5);
      chk("bp_grant_hold", bus.grant_o, 2'd0);
      chk("bp_ready_zero", bus.ready_o, 4'b0000);
    end
    bus.ready_i = 1'b1;
    #1;
    chk("bp_release_ready", bus.ready_o, 4'b0001);
    step();
    chk("bp_next_data", bus.data_o, 32'h5A5A5A5A);

    // Forced channel 3, then forced channel idle so the output drains.
    bus.valid_i     = 4'hF;
    bus.force_en_i  = 1'b1;
    bus.force_sel_i = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("force_grant", bus.grant_o, 2'd3);
    end
    bus.valid_i = 4'b0111;
    step();
    chk("force_idle_valid", bus.valid_o, 1'b0);

    // Out-of-range forced index on the 3-channel instance.
    chk("oor_valid_o", bus3.valid_o, 1'b0);
    chk("oor_ready_o", bus3.ready_o, 3'b000);
    bus3.force_sel_i = 2'd2;
    #1;
    chk("inr_ready_o", bus3.ready_o, 3'b100);
    step();
    chk("inr_valid_o", bus3.valid_o, 1'b1);
    chk("inr_grant_o", bus3.grant_o, 2'd2);

    // Reset in the middle of a locked ch1 packet.
    bus.valid_i     = 4'hF;
    bus.last_i      = 4'h0;
    bus.force_sel_i = 2'd1;
    step();
    bus.force_en_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready_o", bus.ready_o, 4'b0000);
    step();
    chk("midrst_valid_o", bus.valid_o, 1'b0);
    rst_n       = 1'b1;
    bus.last_i  = 4'hF;
    #1;
    chk("midrst_rel_ready", bus.ready_o, 4'b0001);
    step();
    chk("midrst_grant_o", bus.grant_o, 2'd0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
